// File: rtl/dma_pkg.sv
// Copy-engine constants and controller state encoding.
package dma_pkg;

  localparam int unsigned BlockBytes    = 64;
  localparam int unsigned BeatsPerBlock = 4;
  localparam int unsigned SizeLog2      = 6;

  typedef enum logic [2:0] {
    IDLE,
    GET,
    GRESP,
    PUT,
    PACK,
    FIN
  } dma_state_e;

endpackage

// File: rtl/tl_pkg.sv
// Shared TileLink definitions: bus widths, channel opcodes and channel payload structs.
package tl_pkg;

  localparam int unsigned TlDataWidth   = 128;
  localparam int unsigned TlAddrWidth   = 38;
  localparam int unsigned TlSourceWidth = 3;
  localparam int unsigned TlSinkWidth   = 4;
  localparam int unsigned TlSizeWidth   = 4;
  localparam int unsigned TlMaskWidth   = TlDataWidth / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5,
    AcquireBlock   = 3'd6,
    AcquirePerm    = 3'd7
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2,
    Grant         = 3'd4,
    GrantData     = 3'd5,
    ReleaseAck    = 3'd6
  } tl_d_op_e;

  typedef struct packed {
    tl_a_op_e                 opcode;
    logic [2:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic [TlAddrWidth-1:0]   address;
    logic [TlMaskWidth-1:0]   mask;
    logic [TlDataWidth-1:0]   data;
    logic                     corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [1:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic [TlAddrWidth-1:0]   address;
    logic [TlMaskWidth-1:0]   mask;
    logic [TlDataWidth-1:0]   data;
    logic                     corrupt;
  } tl_b_t;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [2:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic [TlAddrWidth-1:0]   address;
    logic [TlDataWidth-1:0]   data;
    logic                     corrupt;
  } tl_c_t;

  typedef struct packed {
    tl_d_op_e                 opcode;
    logic [1:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic [TlSinkWidth-1:0]   sink;
    logic                     denied;
    logic [TlDataWidth-1:0]   data;
    logic                     corrupt;
  } tl_d_t;

  typedef struct packed {
    logic [TlSinkWidth-1:0] sink;
  } tl_e_t;

endpackage

// File: rtl/tl_dma_copy.sv
// TileLink block copier: per 64B block, Get from src into a 4-beat buffer,
// then PutFullData the buffer to dst. One transaction outstanding at a time.
module tl_dma_copy
  import tl_pkg::*;
  import dma_pkg::*;
#(
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned AddrWidth   = 38,
  parameter int unsigned SourceWidth = 3,
  parameter int unsigned SinkWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [15:0]          blocks_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 host_a_valid,
  input  logic                 host_a_ready,
  output tl_a_t                host_a_bits,
  input  logic                 host_b_valid,
  output logic                 host_b_ready,
  input  tl_b_t                host_b_bits,
  output logic                 host_c_valid,
  input  logic                 host_c_ready,
  output tl_c_t                host_c_bits,
  input  logic                 host_d_valid,
  output logic                 host_d_ready,
  input  tl_d_t                host_d_bits,
  output logic                 host_e_valid,
  input  logic                 host_e_ready,
  output tl_e_t                host_e_bits
);

  localparam logic [1:0]             LastBeat = 2'(BeatsPerBlock - 1);
  localparam logic [AddrWidth-1:0]   BlockInc = AddrWidth'(BlockBytes);
  localparam logic [SourceWidth-1:0] SourceId = '0;
  localparam logic [SinkWidth-1:0]   SinkId   = '0;

  dma_state_e           r_state;
  dma_state_e           w_state_next;
  logic [AddrWidth-1:0] r_src;
  logic [AddrWidth-1:0] r_dst;
  logic [15:0]          r_count;
  logic [1:0]           r_beat;
  logic [DataWidth-1:0] r_buf [BeatsPerBlock];
  logic                 r_bad;   // current Get burst returned a bad beat
  logic                 r_err;
  logic                 r_done;
  logic                 w_misaligned;
  logic                 w_d_bad_data;
  logic                 w_d_bad_ack;
  logic                 w_last_beat;
  logic                 w_unused;

  assign w_misaligned = (|src_addr_i[SizeLog2-1:0]) || (|dst_addr_i[SizeLog2-1:0]);
  assign w_d_bad_data = host_d_bits.denied || host_d_bits.corrupt ||
                        (host_d_bits.opcode != AccessAckData);
  assign w_d_bad_ack  = host_d_bits.denied || host_d_bits.corrupt ||
                        (host_d_bits.opcode != AccessAck);
  assign w_last_beat  = (r_beat == LastBeat);

  assign busy_o  = (r_state != IDLE);
  assign done_o  = r_done;
  assign error_o = r_err;

  // Only A and D are used; B is always accepted and C/E stay silent.
  assign host_b_ready = 1'b1;
  assign host_c_valid = 1'b0;
  assign host_c_bits  = '0;
  assign host_e_valid = 1'b0;
  assign host_e_bits  = '{sink: SinkId};

  assign w_unused = ^{host_b_valid, host_b_bits, host_c_ready, host_e_ready,
                      host_d_bits.param, host_d_bits.size, host_d_bits.source,
                      host_d_bits.sink};

  // Next-state logic plus handshake outputs; A payload comes only from registers
  // so it holds steady while a_ready is low.
  always_comb begin
    w_state_next         = r_state;
    host_a_valid         = 1'b0;
    host_d_ready         = 1'b0;
    host_a_bits          = '0;
    host_a_bits.opcode   = Get;
    host_a_bits.param    = 3'd0;
    host_a_bits.size     = 4'(SizeLog2);
    host_a_bits.source   = SourceId;
    host_a_bits.address  = r_src;
    host_a_bits.mask     = '1;
    if (r_state == PUT) begin
      host_a_bits.opcode  = PutFullData;
      host_a_bits.address = r_dst;
      host_a_bits.data    = r_buf[r_beat];
    end
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (blocks_i == 16'd0 || w_misaligned) w_state_next = FIN;
          else                                   w_state_next = GET;
        end
      end
      GET: begin
        host_a_valid = 1'b1;
        if (host_a_ready) w_state_next = GRESP;
      end
      GRESP: begin
        host_d_ready = 1'b1;
        if (host_d_valid && w_last_beat)
          w_state_next = (r_bad || w_d_bad_data) ? FIN : PUT;
      end
      PUT: begin
        host_a_valid = 1'b1;
        if (host_a_ready && w_last_beat) w_state_next = PACK;
      end
      PACK: begin
        host_d_ready = 1'b1;
        if (host_d_valid)
          w_state_next = (w_d_bad_ack || r_count == 16'd1) ? FIN : GET;
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath: latch job, capture read beats, step beat counter and addresses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_beat  <= '0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      for (int unsigned i = 0; i < BeatsPerBlock; i++) r_buf[i] <= '0;
    end else begin
      // done is registered off FIN, so it lands the cycle after FIN.
      r_done <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_src   <= src_addr_i;
            r_dst   <= dst_addr_i;
            r_count <= blocks_i;
            r_beat  <= '0;
            r_bad   <= 1'b0;
            r_err   <= (blocks_i != 16'd0) && w_misaligned;
          end
        end
        GET: begin
          if (host_a_ready) begin
            r_beat <= '0;
            r_bad  <= 1'b0;
          end
        end
        GRESP: begin
          if (host_d_valid) begin
            r_buf[r_beat] <= host_d_bits.data;
            r_beat        <= r_beat + 2'd1;
            if (w_d_bad_data) begin
              r_bad <= 1'b1;
              r_err <= 1'b1;
            end
          end
        end
        PUT: begin
          if (host_a_ready) r_beat <= r_beat + 2'd1;
        end
        PACK: begin
          if (host_d_valid) begin
            if (w_d_bad_ack) begin
              r_err <= 1'b1;
            end else begin
              r_count <= r_count - 16'd1;
              r_src   <= r_src + BlockInc;
              r_dst   <= r_dst + BlockInc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_dma_copy.sv
// Directed bench for tl_dma_copy: the bench plays memory on A/D, drives and
// samples on the falling edge, and checks every A payload against its own model.
module tb_tl_dma_copy;
  import tl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i;
  logic [37:0] src_addr_i;
  logic [37:0] dst_addr_i;
  logic [15:0] blocks_i;
  logic        busy_o, done_o, error_o;
  logic        host_a_valid, host_a_ready;
  tl_a_t       host_a_bits;
  logic        host_b_valid, host_b_ready;
  tl_b_t       host_b_bits;
  logic        host_c_valid, host_c_ready;
  tl_c_t       host_c_bits;
  logic        host_d_valid, host_d_ready;
  tl_d_t       host_d_bits;
  logic        host_e_valid, host_e_ready;
  tl_e_t       host_e_bits;

  int    errors = 0;
  int    checks = 0;
  bit    stall_en = 1'b0;
  bit    have_held = 1'b0;
  tl_a_t held;

  always #5 clk_i = ~clk_i;

  tl_dma_copy #(
    .DataWidth(128), .AddrWidth(38), .SourceWidth(3), .SinkWidth(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .blocks_i(blocks_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a_bits(host_a_bits),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b_bits(host_b_bits),
    .host_c_valid(host_c_valid), .host_c_ready(host_c_ready), .host_c_bits(host_c_bits),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d_bits(host_d_bits),
    .host_e_valid(host_e_valid), .host_e_ready(host_e_ready), .host_e_bits(host_e_bits)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Source memory contents: each beat is a function of block address and beat index.
  function automatic logic [127:0] pat(input logic [37:0] a, input int b);
    logic [31:0] x;
    x = a[31:0];
    return {x, 32'hDEAD_0000 + 32'(b), ~x, 32'h0000_BEEF ^ 32'(b)};
  endfunction

  task automatic chk_a_hdr();
    chk("a_param", 256'(host_a_bits.param), 256'(3'd0));
    chk("a_size", 256'(host_a_bits.size), 256'(4'd6));
    chk("a_source", 256'(host_a_bits.source), 256'(3'd0));
    chk("a_mask", 256'(host_a_bits.mask), 256'(16'hFFFF));
  endtask

  task automatic track_stable();
    if (have_held) chk("a_stable", 256'(host_a_bits), 256'(held));
    if (host_a_valid && !host_a_ready) begin
      held      = host_a_bits;
      have_held = 1'b1;
    end else begin
      have_held = 1'b0;
    end
  endtask

  task automatic do_start(input logic [37:0] s, input logic [37:0] d, input logic [15:0] n);
    host_a_ready = 1'b0;
    host_d_valid = 1'b0;
    src_addr_i   = s;
    dst_addr_i   = d;
    blocks_i     = n;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_get(input logic [37:0] addr);
    bit got;
    got       = 1'b0;
    have_held = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      host_d_valid = 1'b0;
      host_a_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("get_valid", 256'(host_a_valid), 256'(1'b1));
      chk("get_no_dready", 256'(host_d_ready), 256'(1'b0));
      track_stable();
      if (!host_a_valid) break;
      if (host_a_ready) begin
        chk("get_op", 256'(host_a_bits.opcode), 256'(Get));
        chk("get_addr", 256'(host_a_bits.address), 256'(addr));
        chk_a_hdr();
        got = 1'b1;
      end
      @(negedge clk_i);
    end
    if (!got) chk("get_timeout", 256'(got), 256'(1'b1));
  endtask

  // Returns four AccessAckData beats; a request to start meanwhile must be ignored.
  task automatic send_data(input logic [37:0] addr, input int bad_beat);
    int gap;
    for (int b = 0; b < 4; b++) begin
      gap = stall_en ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
        host_a_ready = 1'b0;
        host_d_valid = 1'b0;
        chk("gresp_no_a", 256'(host_a_valid), 256'(1'b0));
        @(negedge clk_i);
      end
      src_addr_i         = 38'h9000;
      blocks_i           = 16'd7;
      start_i            = 1'b1;
      host_a_ready       = 1'b0;
      host_d_valid       = 1'b1;
      host_d_bits        = '0;
      host_d_bits.opcode = AccessAckData;
      host_d_bits.size   = 4'd6;
      host_d_bits.data   = pat(addr, b);
      host_d_bits.denied = (b == bad_beat);
      chk("gresp_dready", 256'(host_d_ready), 256'(1'b1));
      chk("gresp_no_a", 256'(host_a_valid), 256'(1'b0));
      @(negedge clk_i);
    end
    start_i = 1'b0;
  endtask

  task automatic wait_put(input logic [37:0] dst, input logic [37:0] src, input int nbeats);
    bit got;
    have_held = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        host_d_valid = 1'b0;
        host_a_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        chk("put_valid", 256'(host_a_valid), 256'(1'b1));
        chk("put_no_dready", 256'(host_d_ready), 256'(1'b0));
        track_stable();
        if (!host_a_valid) break;
        if (host_a_ready) begin
          chk("put_op", 256'(host_a_bits.opcode), 256'(PutFullData));
          chk("put_addr", 256'(host_a_bits.address), 256'(dst));
          chk("put_data", 256'(host_a_bits.data), 256'(pat(src, b)));
          chk_a_hdr();
          got = 1'b1;
        end
        @(negedge clk_i);
      end
      if (!got) chk("put_timeout", 256'(got), 256'(1'b1));
    end
  endtask

  task automatic send_ack(input logic denied);
    int gap;
    gap = stall_en ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gap; g++) begin
      host_a_ready = 1'b0;
      host_d_valid = 1'b0;
      chk("pack_dready", 256'(host_d_ready), 256'(1'b1));
      chk("pack_no_a", 256'(host_a_valid), 256'(1'b0));
      @(negedge clk_i);
    end
    host_a_ready       = 1'b0;
    host_d_valid       = 1'b1;
    host_d_bits        = '0;
    host_d_bits.opcode = AccessAck;
    host_d_bits.denied = denied;
    chk("pack_dready", 256'(host_d_ready), 256'(1'b1));
    chk("pack_no_done", 256'(done_o), 256'(1'b0));
    @(negedge clk_i);
  endtask

  // Entered in FIN: done must follow one cycle later, exactly once.
  task automatic wait_done(input logic exp_err);
    host_d_valid = 1'b0;
    host_a_ready = 1'b0;
    chk("fin_busy", 256'(busy_o), 256'(1'b1));
    chk("fin_no_done", 256'(done_o), 256'(1'b0));
    chk("fin_no_a", 256'(host_a_valid), 256'(1'b0));
    @(negedge clk_i);
    chk("done_pulse", 256'(done_o), 256'(1'b1));
    chk("done_busy", 256'(busy_o), 256'(1'b0));
    chk("done_err", 256'(error_o), 256'(exp_err));
    chk("done_no_a", 256'(host_a_valid), 256'(1'b0));
    @(negedge clk_i);
    chk("done_once", 256'(done_o), 256'(1'b0));
    chk("idle_busy", 256'(busy_o), 256'(1'b0));
    chk("idle_no_a", 256'(host_a_valid), 256'(1'b0));
    chk("idle_err", 256'(error_o), 256'(exp_err));
  endtask

  task automatic copy_one(input logic [37:0] s, input logic [37:0] d);
    wait_get(s);
    send_data(s, -1);
    wait_put(d, s, 4);
    send_ack(1'b0);
  endtask

  initial begin
    start_i      = 1'b0;
    src_addr_i   = '0;
    dst_addr_i   = '0;
    blocks_i     = '0;
    host_a_ready = 1'b0;
    host_b_valid = 1'b0;
    host_b_bits  = '0;
    host_c_ready = 1'b0;
    host_d_valid = 1'b0;
    host_d_bits  = '0;
    host_e_ready = 1'b0;

    // Reset state and fixed channel ties.
    @(negedge clk_i);
    chk("rst_busy", 256'(busy_o), 256'(1'b0));
    chk("rst_done", 256'(done_o), 256'(1'b0));
    chk("rst_err", 256'(error_o), 256'(1'b0));
    chk("rst_a_valid", 256'(host_a_valid), 256'(1'b0));
    chk("rst_d_ready", 256'(host_d_ready), 256'(1'b0));
    chk("b_ready", 256'(host_b_ready), 256'(1'b1));
    chk("c_valid", 256'(host_c_valid), 256'(1'b0));
    chk("e_valid", 256'(host_e_valid), 256'(1'b0));
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_after_rst", 256'(busy_o), 256'(1'b0));

    // One block, zero-wait memory.
    do_start(38'h1000, 38'h2000, 16'd1);
    copy_one(38'h1000, 38'h2000);
    wait_done(1'b0);

    // Unaligned source: error and done, no A traffic.
    do_start(38'h1010, 38'h2000, 16'd1);
    chk("unal_err_early", 256'(error_o), 256'(1'b1));
    wait_done(1'b1);

    // Zero blocks: done two cycles after start, error cleared by the accepted start.
    do_start(38'h1000, 38'h2000, 16'd0);
    wait_done(1'b0);

    // Three blocks with random A/D stalls.
    stall_en = 1'b1;
    do_start(38'h3000, 38'h8000, 16'd3);
    for (int k = 0; k < 3; k++) copy_one(38'h3000 + 38'(64 * k), 38'h8000 + 38'(64 * k));
    wait_done(1'b0);
    stall_en = 1'b0;

    // Denied Get beat 2 on a 2-block job: burst drained, no Put, second block dropped.
    do_start(38'h5000, 38'h6000, 16'd2);
    wait_get(38'h5000);
    send_data(38'h5000, 2);
    wait_done(1'b1);

    // Address wrap at the top of the 38-bit space.
    do_start(38'h3F_FFFF_FFC0, 38'h100, 16'd2);
    copy_one(38'h3F_FFFF_FFC0, 38'h100);
    copy_one(38'h0, 38'h140);
    wait_done(1'b0);

    // Reset asserted while PUT beat 2 is on the bus.
    do_start(38'h7000, 38'h7800, 16'd1);
    wait_get(38'h7000);
    send_data(38'h7000, -1);
    wait_put(38'h7800, 38'h7000, 2);
    chk("pre_rst_a_valid", 256'(host_a_valid), 256'(1'b1));
    host_a_ready = 1'b0;
    rst_i        = 1'b1;
    #1;
    chk("midrst_a_valid", 256'(host_a_valid), 256'(1'b0));
    chk("midrst_busy", 256'(busy_o), 256'(1'b0));
    chk("midrst_d_ready", 256'(host_d_ready), 256'(1'b0));
    chk("midrst_err", 256'(error_o), 256'(1'b0));
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("postrst_no_a", 256'(host_a_valid), 256'(1'b0));
    chk("postrst_busy", 256'(busy_o), 256'(1'b0));
    do_start(38'hA000, 38'hB000, 16'd1);
    copy_one(38'hA000, 38'hB000);
    wait_done(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_dma_copy.md
TL_DMA_COPY -- requirements
Module: tl_dma_copy

Interface
REQ-001 Parameter DataWidth, default 128: TileLink data bus width in bits; fixed at 128.
REQ-002 Parameter AddrWidth, default 38: TileLink address width in bits.
REQ-003 Parameter SourceWidth, default 3: A-channel source ID width in bits.
REQ-004 Parameter SinkWidth, default 4: D-channel sink ID width in bits.
REQ-005 clk_i, input, 1 bit: the block's only clock. One clock, no other clock domains.
REQ-006 rst_i, input, 1 bit: reset, asynchronous assert, active-high.
REQ-007 start_i, input, 1 bit: one-cycle request to begin a copy.
REQ-008 src_addr_i, input, AddrWidth bits: source base address; must be 64B-aligned.
REQ-009 dst_addr_i, input, AddrWidth bits: destination base address; must be 64B-aligned.
REQ-010 blocks_i, input, 16 bits: number of 64B blocks to copy.
REQ-011 busy_o, output, 1 bit: high while a copy is in progress.
REQ-012 done_o, output, 1 bit: one-cycle pulse when a copy ends.
REQ-013 error_o, output, 1 bit: sticky error flag; cleared by the next accepted start.
REQ-014 TileLink host port named host: A, B, C, D and E channels, each a valid/ready pair plus the codebase TL channel struct, sized by the parameters above.

Function
REQ-015 The block SHALL use only channels A and D; host_b_ready=1, host_c_valid=0, host_e_valid=0 at all times.
REQ-016 Every A message SHALL carry param=0, size=6, source=0, and mask all-ones.
REQ-017 States SHALL be IDLE, GET, GRESP, PUT, PACK, FIN.
REQ-018 IDLE: start_i SHALL latch src, dst and count.
 - count=0 -> FIN.
 - src or dst not 64B-aligned -> set error, -> FIN.
 - otherwise -> GET.
REQ-019 start_i outside IDLE SHALL be ignored.
REQ-020 GET: drive a_valid with opcode Get, address=src; on a_ready -> GRESP.
REQ-021 GRESP: d_ready=1; capture each AccessAckData beat into a 4x128 buffer, indexed by a 2-bit beat counter; after beat 3 -> PUT.
REQ-022 Any D beat with denied or corrupt set SHALL set error.
 - Remaining beats of the burst are still drained.
 - Then -> FIN, with no Put issued for that block.
REQ-023 PUT: drive 4 PutFullData beats, address=dst on every beat, data=buffer[beat].
 - The beat counter advances only on a_valid&&a_ready.
 - a_valid stays high between beats.
 - After beat 3 -> PACK.
REQ-024 PACK: d_ready=1; accept one AccessAck.
 - denied -> set error, -> FIN.
 - else decrement count and add 64 to src and dst, wrapping modulo 2^AddrWidth.
 - count reaches 0 -> FIN, else -> GET.
REQ-025 At most one transaction SHALL be outstanding; d_ready=0 in IDLE, GET, PUT and FIN.
REQ-026 A payload SHALL hold stable while a_valid=1 and a_ready=0.
REQ-027 FIN: done_o=1 for exactly one cycle, then -> IDLE.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 A D beat with an unexpected opcode (AccessAck in GRESP, or AccessAckData in PACK) SHALL set error and be handled as in REQ-022.
REQ-030 An A handshake and a D beat SHALL never be required in the same cycle, because of REQ-025.

Reset
REQ-031 While rst_i=1 the block SHALL be held as follows, regardless of prior state:
 - state=IDLE;
 - busy_o=0, done_o=0, error_o=0;
 - a_valid=0, d_ready=0;
 - all counters and addresses = 0.
REQ-032 Reset mid-copy SHALL abandon the transfer; no A beat is issued in the first cycle after deassertion.

Structure
REQ-033 TL opcode and struct definitions SHALL come from the existing shared TL package.
REQ-034 The state enum and constants SHALL live in a new package dma_pkg: BlockBytes=64, BeatsPerBlock=4, SizeLog2=6.
REQ-035 The block SHALL be a single module with no sub-modules; the 4x128 buffer is inline flops.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
 - Copy 1 block, src=0x1000, dst=0x2000, zero-wait memory model -> one Get, 4 Put beats at 0x2000 matching the source data, done_o pulse, error_o=0.
 - blocks=3, random a_ready/d_valid stalls -> 3 Get/Put pairs at src+0/+0x40/+0x80 and dst likewise, A payload stable under stall, single done_o.
 - blocks=0 -> done_o exactly 2 cycles after start, no A traffic.
 - src=0x1010 (unaligned) -> error_o=1 and done_o, no A traffic.
 - Get response beat 2 has denied=1, blocks=2 -> all 4 beats drained, no Put issued, error_o=1, done_o, second block not started.
 - rst_i asserted during PUT beat 2 -> a_valid=0 and busy_o=0 immediately; a subsequent start for 1 block completes normally.
